// File: rtl/anc_engine.sv
// Sequential noise canceller: an IIR-smoothed reference feeds an NTAPS-tap LMS FIR, error is emitted.
// Build option: define ANC_LEAKY_LMS_EN for leaky LMS weight updates (w -= w >>> 8 each update).
module anc_engine #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NTAPS     = 4,
  parameter int unsigned COEF_W    = 18,
  parameter int unsigned IIR_SHIFT = 2,
  parameter int unsigned MU_SHIFT  = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [DATA_W-1:0] ref_data_i,
  input  logic [1:0]        mode_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [2:0]        state_o,
  output logic              sat_flag_o
);
  localparam int unsigned Dw1   = DATA_W + 1;
  localparam int unsigned Pw2   = 2 * DATA_W;
  localparam int unsigned AccW  = 2 * DATA_W + $clog2(NTAPS) + 2;
  localparam int unsigned ProdW = COEF_W + DATA_W;
  localparam int unsigned UpdW  = 2 * DATA_W + 2;
  localparam int unsigned UpdSh = 2 * DATA_W - COEF_W + MU_SHIFT;
  localparam int unsigned TapW  = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  localparam logic signed [DATA_W-1:0] DMax = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMin = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [COEF_W-1:0] CMax = {1'b0, {(COEF_W-1){1'b1}}};
  localparam logic signed [COEF_W-1:0] CMin = {1'b1, {(COEF_W-1){1'b0}}};

  localparam logic [1:0] ModeBypass = 2'b00;
  localparam logic [1:0] ModeIir    = 2'b01;
  localparam logic [1:0] ModeAnc    = 2'b10;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StIir  = 3'd1,
    StMac  = 3'd2,
    StOut  = 3'd3,
    StUpd  = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               mode_q;
  logic signed [DATA_W-1:0] in_q, ref_q, s_q, out_q;
  logic signed [DATA_W-1:0] x_q [NTAPS];
  logic signed [COEF_W-1:0] w_q [NTAPS];
  logic signed [AccW-1:0]   acc_q;
  logic [TapW-1:0]          tap_q;
  logic                     sat_q, run_q;

  logic                     accept, last_tap;
  logic signed [Dw1-1:0]    iir_diff, iir_sum, e_sum;
  logic signed [DATA_W-1:0] s_new, y_val, e_val;
  logic signed [ProdW-1:0]  mac_prod;
  logic signed [AccW-1:0]   acc_sum, y_sh;
  logic signed [Pw2-1:0]    upd_prod, upd_step;
  logic signed [UpdW-1:0]   w_sum;
  logic signed [COEF_W-1:0] w_new;
  logic                     iir_clamp, y_clamp, e_clamp, w_clamp;

  always_comb begin
    accept   = in_valid_i & in_ready_o;
    last_tap = (tap_q == TapW'(NTAPS - 1));

    iir_diff  = Dw1'(ref_q) - Dw1'(s_q);
    iir_sum   = Dw1'(s_q) + (iir_diff >>> IIR_SHIFT);
    iir_clamp = iir_sum[DATA_W] != iir_sum[DATA_W-1];
    s_new     = iir_clamp ? (iir_sum[DATA_W] ? DMin : DMax) : iir_sum[DATA_W-1:0];

    mac_prod = ProdW'(w_q[tap_q]) * ProdW'(x_q[tap_q]);
    acc_sum  = acc_q + AccW'(mac_prod);
    y_sh     = acc_sum >>> (COEF_W - 2);
    y_clamp  = !((&y_sh[AccW-1:DATA_W-1]) || !(|y_sh[AccW-1:DATA_W-1]));
    y_val    = y_clamp ? (y_sh[AccW-1] ? DMin : DMax) : y_sh[DATA_W-1:0];
    e_sum    = Dw1'(in_q) - Dw1'(y_val);
    e_clamp  = e_sum[DATA_W] != e_sum[DATA_W-1];
    e_val    = e_clamp ? (e_sum[DATA_W] ? DMin : DMax) : e_sum[DATA_W-1:0];

    // out_q holds the error e while in UPD
    upd_prod = Pw2'(out_q) * Pw2'(x_q[tap_q]);
    upd_step = upd_prod >>> UpdSh;
    w_sum    = UpdW'(w_q[tap_q]) + UpdW'(upd_step);
`ifdef ANC_LEAKY_LMS_EN
    w_sum    = w_sum - UpdW'(w_q[tap_q] >>> 8);
`endif
    w_clamp  = !((&w_sum[UpdW-1:COEF_W-1]) || !(|w_sum[UpdW-1:COEF_W-1]));
    w_new    = w_clamp ? (w_sum[UpdW-1] ? CMin : CMax) : w_sum[COEF_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = (mode_i == ModeBypass) ? StOut : StIir;
      StIir:  state_d = (mode_q == ModeIir) ? StOut : StMac;
      StMac:  if (last_tap) state_d = StOut;
      StOut:  if (out_ready_i) state_d = (mode_q == ModeAnc) ? StUpd : StIdle;
      StUpd:  if (last_tap) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready_o  = run_q && (state_q == StIdle);
    out_valid_o = (state_q == StOut);
    out_data_o  = out_q;
    state_o     = state_q;
    sat_flag_o  = sat_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= '0;
      in_q   <= '0;
      ref_q  <= '0;
      s_q    <= '0;
      out_q  <= '0;
      acc_q  <= '0;
      tap_q  <= '0;
      sat_q  <= 1'b0;
      run_q  <= 1'b0;
      for (int k = 0; k < int'(NTAPS); k++) begin
        x_q[k] <= '0;
        w_q[k] <= '0;
      end
    end else begin
      run_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            mode_q <= mode_i;
            in_q   <= in_data_i;
            ref_q  <= ref_data_i;
            if (mode_i == ModeBypass) out_q <= in_data_i;
          end
        end
        StIir: begin
          s_q    <= s_new;
          x_q[0] <= s_new;
          for (int k = 1; k < int'(NTAPS); k++) x_q[k] <= x_q[k-1];
          acc_q  <= '0;
          tap_q  <= '0;
          if (mode_q == ModeIir) out_q <= s_new;
          if (iir_clamp) sat_q <= 1'b1;
        end
        StMac: begin
          acc_q <= acc_sum;
          if (last_tap) begin
            tap_q <= '0;
            out_q <= e_val;
            if (y_clamp || e_clamp) sat_q <= 1'b1;
          end else begin
            tap_q <= tap_q + TapW'(1);
          end
        end
        StUpd: begin
          w_q[tap_q] <= w_new;
          tap_q      <= last_tap ? '0 : tap_q + TapW'(1);
          if (w_clamp) sat_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_anc_engine.sv
// Scoreboard bench for anc_engine: a behavioural model predicts each result at stimulus time.
module tb_anc_engine;
  localparam int DW = 16;
  localparam int NT = 4;
  localparam int CW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] ref_data = '0;
  logic [1:0]    mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [2:0]    state;
  logic          sat_flag;

  always #5 clk = ~clk;

  anc_engine dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .ref_data_i (ref_data),
    .mode_i     (mode),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .state_o    (state),
    .sat_flag_o (sat_flag)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sat;
  } exp_t;

  exp_t   exp_q[$];
  int     total = 0;
  int     bad = 0;
  longint ms;
  longint mx[NT];
  longint mw[NT];
  bit     msat;

  function automatic longint clampv(input longint v, input int bits);
    longint hi = (longint'(1) << (bits - 1)) - 1;
    longint lo = -hi - 1;
    if (v > hi) begin msat = 1'b1; return hi; end
    if (v < lo) begin msat = 1'b1; return lo; end
    return v;
  endfunction

  task automatic model_reset();
    ms = 0;
    msat = 1'b0;
    for (int k = 0; k < NT; k++) begin mx[k] = 0; mw[k] = 0; end
    exp_q.delete();
  endtask

  task automatic model_step(input logic [1:0] m, input logic [DW-1:0] din, input logic [DW-1:0] dref);
    longint iv = longint'($signed(din));
    longint rv = longint'($signed(dref));
    longint acc, y, e, res, nw;
    exp_t ex;
    if (m == 2'b00) res = iv;
    else begin
      ms = clampv(ms + ((rv - ms) >>> 2), DW);
      for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = ms;
      if (m == 2'b01) res = ms;
      else begin
        acc = 0;
        for (int k = 0; k < NT; k++) acc += mw[k] * mx[k];
        y = clampv(acc >>> (CW - 2), DW);
        e = clampv(iv - y, DW);
        res = e;
      end
    end
    ex.data = res[DW-1:0];
    ex.sat  = msat;
    exp_q.push_back(ex);
    if (m == 2'b10) begin
      for (int k = 0; k < NT; k++) begin
        nw = mw[k] + ((e * mx[k]) >>> (2 * DW - CW + 6));
`ifdef ANC_LEAKY_LMS_EN
        nw = nw - (mw[k] >>> 8);
`endif
        mw[k] = clampv(nw, CW);
      end
    end
  endtask

  // Offer one sample, wait for the accept, then wait for out_valid; lat counts sample points.
  task automatic drive_sample(input logic [1:0] m, input logic [DW-1:0] din, input logic [DW-1:0] dref,
                              output int lat, output bit tmo);
    int n = 0;
    model_step(m, din, dref);
    mode = m; in_data = din; ref_data = dref; in_valid = 1'b1;
    tmo = 1'b0;
    while (in_ready !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
    if (in_ready !== 1'b1) tmo = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; mode = ~m; in_data = ~din; ref_data = ~dref;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
    if (out_valid !== 1'b1) tmo = 1'b1;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (in_ready !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (out_data !== 16'h0000 || sat_flag !== 1'b0) begin
      bad++; $display("FAIL reset_data_sat got=%h/%b want=0000/0", out_data, sat_flag);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL release_ready_early got=%b want=0", in_ready); end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_bypass();
    int lat; bit tmo; exp_t ex;
    drive_sample(2'b00, 16'h1234, 16'h7777, lat, tmo);
    ex = exp_q.pop_front();
    total++; if (tmo || lat != 1) begin bad++; $display("FAIL bypass_latency got=%0d want=1", lat); end
    total++; if (out_data !== 16'h1234 || out_data !== ex.data) begin
      bad++; $display("FAIL bypass_data got=%h want=%h", out_data, ex.data);
    end
    take();
    total++; if (out_valid !== 1'b0 || state !== 3'd0) begin
      bad++; $display("FAIL bypass_exit got=%b/%0d want=0/0", out_valid, state);
    end
  endtask

  task automatic test_iir_step();
    logic [DW-1:0] want [3];
    int lat; bit tmo; exp_t ex;
    want[0] = 16'h1000; want[1] = 16'h1C00; want[2] = 16'h2500;
    for (int i = 0; i < 3; i++) begin
      drive_sample(2'b01, 16'h5555, 16'h4000, lat, tmo);
      ex = exp_q.pop_front();
      total++; if (tmo || lat != 2) begin bad++; $display("FAIL iir_latency[%0d] got=%0d want=2", i, lat); end
      total++; if (out_data !== want[i] || out_data !== ex.data) begin
        bad++; $display("FAIL iir_data[%0d] got=%h want=%h", i, out_data, want[i]);
      end
      take();
    end
  endtask

  task automatic test_adaptive_first();
    int lat; bit tmo; exp_t ex;
    do_reset();
    drive_sample(2'b10, 16'h4000, 16'h4000, lat, tmo);
    ex = exp_q.pop_front();
    total++; if (tmo || lat != 2 + NT) begin bad++; $display("FAIL anc_latency got=%0d want=%0d", lat, 2 + NT); end
    total++; if (out_data !== 16'h4000 || out_data !== ex.data) begin
      bad++; $display("FAIL anc_data got=%h want=%h", out_data, ex.data);
    end
    take();
    total++; if (state !== 3'd4) begin bad++; $display("FAIL anc_upd_state got=%0d want=4", state); end
    wait_idle();
    for (int k = 0; k < NT; k++) begin
      total++;
      if (dut.w_q[k] !== ((k == 0) ? 18'd64 : 18'd0) || 64'(dut.w_q[k]) !== 64'(mw[k])) begin
        bad++; $display("FAIL anc_weight[%0d] got=%0d want=%0d", k, dut.w_q[k], mw[k]);
      end
    end
  endtask

  task automatic test_frozen();
    int lat; bit tmo; exp_t ex;
    do_reset();
    drive_sample(2'b11, 16'h4000, 16'h4000, lat, tmo);
    ex = exp_q.pop_front();
    total++; if (tmo || lat != 2 + NT || out_data !== ex.data) begin
      bad++; $display("FAIL frozen_data got=%h lat=%0d want=%h lat=%0d", out_data, lat, ex.data, 2 + NT);
    end
    take();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL frozen_skip_upd got=%0d want=0", state); end
    wait_idle();
    total++; if (dut.w_q[0] !== 18'd0) begin bad++; $display("FAIL frozen_w0 got=%0d want=0", dut.w_q[0]); end
  endtask

  task automatic test_back_pressure();
    int lat; bit tmo; exp_t ex; longint w0_pre;
    w0_pre = mw[0];
    drive_sample(2'b10, 16'h3000, 16'h2000, lat, tmo);
    ex = exp_q.pop_front();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (tmo || out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== ex.data ||
          64'(dut.w_q[0]) !== 64'(w0_pre)) begin
        bad++; $display("FAIL stall[%0d] got=%b/%b/%h/%0d want=1/0/%h/%0d", i, out_valid, in_ready,
                        out_data, dut.w_q[0], ex.data, w0_pre);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    take();
    total++; if (out_valid !== 1'b0 || out_data !== ex.data) begin
      bad++; $display("FAIL stall_single_transfer got=%b/%h want=0/%h", out_valid, out_data, ex.data);
    end
    wait_idle();
    total++; if (64'(dut.w_q[0]) !== 64'(mw[0])) begin
      bad++; $display("FAIL stall_upd_w0 got=%0d want=%0d", dut.w_q[0], mw[0]);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit tmo; exp_t ex; logic [1:0] m;
    for (int i = 0; i < 24; i++) begin
      m = 2'($urandom_range(3, 0));
      drive_sample(m, 16'($urandom), 16'($urandom), lat, tmo);
      ex = exp_q.pop_front();
      repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
      total++; if (tmo || out_data !== ex.data || sat_flag !== ex.sat) begin
        bad++; $display("FAIL b2b[%0d] mode=%0d got=%h/%b want=%h/%b", i, m, out_data, sat_flag, ex.data, ex.sat);
      end
      take();
    end
  endtask

  // Small reference makes the LMS solution exceed the weight range, driving w toward +max.
  task automatic test_saturation();
    int lat; bit tmo; exp_t ex; int i = 0;
    do_reset();
    while (mw[0] != 131071 && i < 4000) begin
      drive_sample(2'b10, 16'h7FFF, 16'h0C00, lat, tmo);
      ex = exp_q.pop_front();
      total++; if (tmo || out_data !== ex.data || sat_flag !== ex.sat) begin
        bad++; $display("FAIL sat_run[%0d] got=%h/%b want=%h/%b", i, out_data, sat_flag, ex.data, ex.sat);
      end
      take();
      i++;
    end
    wait_idle();
    total++; if (dut.w_q[0] !== 18'h1FFFF) begin bad++; $display("FAIL sat_w0 got=%h want=1ffff", dut.w_q[0]); end
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b want=1", sat_flag); end
    drive_sample(2'b01, 16'h0000, 16'h0000, lat, tmo);
    ex = exp_q.pop_front();
    total++; if (tmo || sat_flag !== 1'b1 || out_data !== ex.data) begin
      bad++; $display("FAIL sat_sticky got=%b/%h want=1/%h", sat_flag, out_data, ex.data);
    end
    take();
  endtask

  task automatic test_reset_mid_mac();
    int lat; bit tmo; exp_t ex; int n = 0;
    wait_idle();
    mode = 2'b10; in_data = 16'h1234; ref_data = 16'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (state !== 3'd2 && n < 16) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    total++; if (state !== 3'd2 || sat_flag !== 1'b1) begin
      bad++; $display("FAIL pre_reset got=%0d/%b want=2/1", state, sat_flag);
    end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || state !== 3'd0 || sat_flag !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_mac_reset got=%b/%0d/%b/%b want=0/0/0/0", out_valid, state, sat_flag, in_ready);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_sample(2'b10, 16'h1234, 16'h4000, lat, tmo);
    ex = exp_q.pop_front();
    total++; if (tmo || out_data !== 16'h1234 || out_data !== ex.data) begin
      bad++; $display("FAIL post_reset_anc got=%h want=%h", out_data, ex.data);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_iir_step();
    test_adaptive_first();
    test_frozen();
    test_back_pressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid_mac();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
